minmax_window: RTL

Parametrised, windowed min/max/peak detector for the AGC datapath; the sequential successor to the two-input signed max comparator. It consumes a stream of signed samples under a valid qualifier and reduces each block of WINDOW_LEN accepted samples to one result: maximum, minimum or saturated absolute peak. It emits one result per window with a single-cycle strobe. It sits between the input sample path and the AGC gain-update logic as the level detector.

---
 rtl/minmax_window.sv | 139 +++++++++++++
 1 files changed

// File: rtl/minmax_window.sv
// Windowed min / max / saturated-abs-peak level detector for the AGC path.
// Reduces each block of WINDOW_LEN accepted signed samples to a single strobed result.
module minmax_window #(
  parameter  int WIDTH      = 8,
  parameter  int WINDOW_LEN = 16,
  localparam int CNT_W      = $clog2(WINDOW_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enb,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic        [1:0]       mode,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out_data,
  output logic signed [WIDTH-1:0] run_data,
  output logic                    busy,
  output logic        [CNT_W-1:0] sample_cnt
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  localparam logic [1:0]             MODE_MIN = 2'b01;
  localparam logic [1:0]             MODE_ABS = 2'b10;
  localparam logic signed [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0]       LAST_CNT = CNT_W'(WINDOW_LEN - 1);

  state_t                  state_q;
  logic        [1:0]       mode_q;
  logic signed [WIDTH-1:0] acc_q;
  logic signed [WIDTH-1:0] acc_d;
  logic signed [WIDTH-1:0] out_data_q;
  logic                    out_valid_q;
  logic                    busy_q;
  logic        [CNT_W-1:0] cnt_q;
  logic        [1:0]       mode_eff_s;
  logic signed [WIDTH-1:0] fx_s;
  logic                    last_s;

  // Sample transform, reduction and window-completion detect.
  // The first sample of a window uses the live mode; later ones use the latched mode.
  always_comb begin
    mode_eff_s = mode_q;
    fx_s       = in_data;
    acc_d      = acc_q;
    last_s     = 1'b0;

    if (state_q == ST_EMPTY) begin
      mode_eff_s = mode;
    end else begin
      mode_eff_s = mode_q;
    end

    case (mode_eff_s)
      MODE_ABS: begin
        if (in_data == MIN_NEG) begin
          fx_s = MAX_POS;
        end else if (in_data[WIDTH-1]) begin
          fx_s = -in_data;
        end else begin
          fx_s = in_data;
        end
      end
      default: fx_s = in_data;
    endcase

    // Strict compares so that ties keep the existing accumulator.
    if (state_q == ST_EMPTY) begin
      acc_d = fx_s;
    end else if (mode_eff_s == MODE_MIN) begin
      acc_d = (fx_s < acc_q) ? fx_s : acc_q;
    end else begin
      acc_d = (fx_s > acc_q) ? fx_s : acc_q;
    end

    if (state_q == ST_EMPTY) begin
      last_s = (WINDOW_LEN == 1);
    end else begin
      last_s = (cnt_q == LAST_CNT);
    end
  end

  // Window FSM, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      mode_q      <= 2'b00;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      // The strobe is single-cycle even when enb drops right after it.
      out_valid_q <= 1'b0;
      if (enb) begin
        if (clear) begin
          state_q <= ST_EMPTY;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end else if (in_valid) begin
          acc_q <= acc_d;
          if (state_q == ST_EMPTY) begin
            mode_q <= mode;
          end else begin
            mode_q <= mode_q;
          end
          if (last_s) begin
            out_data_q  <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_EMPTY;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
          end else begin
            state_q <= ST_ACCUM;
            busy_q  <= 1'b1;
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end else begin
          state_q <= state_q;
        end
      end else begin
        state_q <= state_q;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign run_data   = acc_q;
  assign busy       = busy_q;
  assign sample_cnt = cnt_q;

endmodule
